// File: rtl/regfile_pkg.sv
// Shared widths, FSM state and bundle types for the operand-fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  // Operand stage occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Issued instruction as seen on the issue port.
  typedef struct packed {
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic              wr_en;
  } iss_t;

  // Contents of the one-entry operand stage.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] dst;
    logic              wr_en;
  } opd_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Issue, operand, writeback and register-file port bundle of the sequencer.
// Latency: n/a (wires only).
// Backpressure: iss_ready/opd_ready handshakes; writeback has no ready.
interface regfile_access_ctrl_if;
  import regfile_pkg::*;

  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] iss_src_a;
  logic [ADDR_W-1:0] iss_src_b;
  logic [ADDR_W-1:0] iss_dst;
  logic              iss_wr_en;

  logic              opd_valid;
  logic              opd_ready;
  logic [DATA_W-1:0] opd_a;
  logic [DATA_W-1:0] opd_b;
  logic [ADDR_W-1:0] opd_dst;
  logic              opd_wr_en;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;

  logic [ADDR_W-1:0] rf_a1;
  logic [ADDR_W-1:0] rf_a2;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;

  // master: the sequencer; slave: issuer, consumer, writeback source and register file.
  modport master (
    input  iss_valid, iss_src_a, iss_src_b, iss_dst, iss_wr_en,
    output iss_ready,
    output opd_valid, opd_a, opd_b, opd_dst, opd_wr_en,
    input  opd_ready,
    input  wb_valid, wb_dst, wb_data,
    output rf_a1, rf_a2, rf_a3, rf_wd, rf_we,
    input  rf_rd1, rf_rd2
  );

  modport slave (
    output iss_valid, iss_src_a, iss_src_b, iss_dst, iss_wr_en,
    input  iss_ready,
    input  opd_valid, opd_a, opd_b, opd_dst, opd_wr_en,
    output opd_ready,
    output wb_valid, wb_dst, wb_data,
    input  rf_a1, rf_a2, rf_a3, rf_wd, rf_we,
    output rf_rd1, rf_rd2
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with same-cycle writeback release and RAW/WAW hazard detect.
// Latency: hazard is combinational; busy updates on the next clk edge.
// Backpressure: none itself; hazard feeds the issue ready.
module rf_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic              dst_en,
  output logic [NREGS-1:0]  busy,
  output logic              hazard
);

  logic blk_a, blk_b, blk_d;

  // A register still counts as pending unless this cycle's writeback targets it.
  always_comb begin
    blk_a  = busy[src_a] && !(clr_en && (clr_idx == src_a));
    blk_b  = busy[src_b] && !(clr_en && (clr_idx == src_b));
    blk_d  = busy[dst]   && !(clr_en && (clr_idx == dst));
    hazard = blk_a || blk_b || (dst_en && blk_d);
  end

  // Busy vector: the set is written last so it wins over a clear to the same index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch/writeback sequencer: issue handshake, RF read/write ports, bypassed operand stage.
// Latency: accept at edge N -> opd_valid after edge N; one instruction per cycle when unblocked.
// Backpressure: iss_ready drops on hazard or on a full stage with opd_ready low; writeback never blocked.
module regfile_access_ctrl
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  regfile_access_ctrl_if.master bus,
  output logic                  wb_err,
  output logic [15:0]           stall_cnt
);

  iss_t              iss;
  opd_t              opd_q;
  state_t            state_q;
  state_t            state_d;
  logic [NREGS-1:0]  busy;
  logic              hazard;
  logic              accept;
  logic              wb_hit_a;
  logic              wb_hit_b;
  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;

  assign iss = '{src_a: bus.iss_src_a, src_b: bus.iss_src_b,
                 dst: bus.iss_dst, wr_en: bus.iss_wr_en};

  // Register file ports: reads follow the issue payload, writes follow the writeback.
  assign bus.rf_a1 = iss.src_a;
  assign bus.rf_a2 = iss.src_b;
  assign bus.rf_a3 = bus.wb_dst;
  assign bus.rf_wd = bus.wb_data;
  assign bus.rf_we = bus.wb_valid & rst;

  rf_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept && iss.wr_en),
    .set_idx (iss.dst),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_dst),
    .src_a   (iss.src_a),
    .src_b   (iss.src_b),
    .dst     (iss.dst),
    .dst_en  (iss.wr_en),
    .busy    (busy),
    .hazard  (hazard)
  );

  assign bus.iss_ready = rst && !hazard && ((state_q == EMPTY) || bus.opd_ready);
  assign accept        = bus.iss_valid && bus.iss_ready;

  // Same-edge RF write is not yet visible on the read ports, so take it from the writeback bus.
  always_comb begin
    wb_hit_a = bus.wb_valid && (bus.wb_dst == iss.src_a);
    wb_hit_b = bus.wb_valid && (bus.wb_dst == iss.src_b);
    byp_a    = wb_hit_a ? bus.wb_data : bus.rf_rd1;
    byp_b    = wb_hit_b ? bus.wb_data : bus.rf_rd2;
  end

  // Operand stage occupancy: a full stage reloads or drains only when the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (bus.opd_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset drops any held instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Operand payload loads only on accept, so it is stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        opd_q <= '0;
    else if (accept) opd_q <= '{a: byp_a, b: byp_b, dst: iss.dst, wr_en: iss.wr_en};
  end

  assign bus.opd_valid = (state_q == FULL);
  assign bus.opd_a     = opd_q.a;
  assign bus.opd_b     = opd_q.b;
  assign bus.opd_dst   = opd_q.dst;
  assign bus.opd_wr_en = opd_q.wr_en;

  // Sticky flag for a writeback arriving at a register nobody was waiting on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   wb_err <= 1'b0;
    else if (bus.wb_valid && !busy[bus.wb_dst]) wb_err <= 1'b1;
  end

  // Saturating count of cycles an offered issue was held back by a hazard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (bus.iss_valid && hazard && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: directed vector table, hand sequences and a randomized model comparison.
// Latency: drives on negedge, checks combinational outputs #1 later and registered ones #1 after posedge.
// Backpressure: random opd_ready; issuer holds its request until accepted.
module tb_regfile_access_ctrl;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_err;
  logic [15:0] stall_cnt;
  logic [DATA_W-1:0] rf_mem [NREGS];

  int n_chk  = 0;
  int n_pass = 0;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wb_err    (wb_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, clocked write, preloaded while reset is held.
  assign bus.rf_rd1 = rf_mem[bus.rf_a1];
  assign bus.rf_rd2 = rf_mem[bus.rf_a2];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
      rf_mem[1] <= 16'd20;
      rf_mem[2] <= 16'd20;
      rf_mem[6] <= 16'd90;
      rf_mem[7] <= 16'd1;
    end else if (bus.rf_we) begin
      rf_mem[bus.rf_a3] <= bus.rf_wd;
    end
  end

  typedef struct {
    int iv, sa, sb, d, we, ordy, wv, wd, wdat;
    int exp_rdy, exp_ov, exp_a, exp_b, exp_dst, exp_busy, exp_stall;
  } vec_t;
  vec_t vt[$];

  // Reference model state.
  logic [NREGS-1:0]  m_busy;
  logic              m_ov, m_we, m_err;
  logic [DATA_W-1:0] m_a, m_b;
  logic [ADDR_W-1:0] m_dst;
  int                m_stall;
  logic              ha, hb, hd, haz, rdy, acc, last_acc;
  logic              s_iv, s_we, s_ordy, s_wv;
  logic [ADDR_W-1:0] s_d, s_wd;
  logic [DATA_W-1:0] na, nb;
  int                k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input int iv, sa, sb, d, we, ordy, wv, wd, wdat);
    bus.iss_valid = iv[0];
    bus.iss_src_a = sa[ADDR_W-1:0];
    bus.iss_src_b = sb[ADDR_W-1:0];
    bus.iss_dst   = d[ADDR_W-1:0];
    bus.iss_wr_en = we[0];
    bus.opd_ready = ordy[0];
    bus.wb_valid  = wv[0];
    bus.wb_dst    = wd[ADDR_W-1:0];
    bus.wb_data   = wdat[DATA_W-1:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    #2 rst = 1'b0;

    // Reset state, with live requests that must be ignored.
    @(negedge clk);
    drive(1, 1, 6, 3, 1, 1, 1, 5, 16'h1234);
    #1;
    check("rst iss_ready", bus.iss_ready, 0);
    check("rst rf_we", bus.rf_we, 0);
    check("rst opd_valid", bus.opd_valid, 0);
    check("rst opd_a", bus.opd_a, 0);
    check("rst opd_b", bus.opd_b, 0);
    check("rst opd_dst", bus.opd_dst, 0);
    check("rst opd_wr_en", bus.opd_wr_en, 0);
    check("rst busy", dut.u_sb.busy, 0);
    check("rst wb_err", wb_err, 0);
    check("rst stall_cnt", stall_cnt, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;

    //            iv sa sb d we ordy wv wd wdat   rdy ov  a   b  dst busy  stall
    vt.push_back('{1, 1, 6, 3, 1, 0,   0, 0, 0,    1,  1, 20, 90, 3, 'h08, 0}); // basic issue
    vt.push_back('{1, 3, 1, 4, 1, 1,   0, 0, 0,    0,  0, 0,  0,  0, 'h08, 1}); // RAW stall
    vt.push_back('{1, 3, 1, 4, 1, 1,   0, 0, 0,    0,  0, 0,  0,  0, 'h08, 2});
    vt.push_back('{1, 3, 1, 4, 1, 1,   0, 0, 0,    0,  0, 0,  0,  0, 'h08, 3});
    vt.push_back('{1, 3, 1, 4, 1, 1,   1, 3, 40,   1,  1, 40, 20, 4, 'h10, 3}); // same-cycle release
    vt.push_back('{1, 2, 7, 0, 0, 0,   0, 0, 0,    0,  1, 40, 20, 4, 'h10, 3}); // backpressure hold
    vt.push_back('{1, 2, 7, 0, 0, 0,   0, 0, 0,    0,  1, 40, 20, 4, 'h10, 3});
    vt.push_back('{1, 2, 7, 0, 0, 1,   0, 0, 0,    1,  1, 20, 1,  0, 'h10, 3}); // drain + reload
    vt.push_back('{1, 0, 0, 7, 1, 1,   0, 0, 0,    1,  1, 0,  0,  7, 'h90, 3});
    vt.push_back('{1, 1, 2, 7, 1, 1,   0, 0, 0,    0,  0, 0,  0,  0, 'h90, 4}); // WAW stall
    vt.push_back('{1, 1, 2, 7, 1, 1,   1, 7, 55,   1,  1, 20, 20, 7, 'h90, 4}); // set beats clear
    vt.push_back('{0, 0, 0, 0, 0, 1,   1, 4, 9,    1,  0, 0,  0,  0, 'h80, 4});
    vt.push_back('{0, 0, 0, 0, 0, 1,   1, 7, 3,    1,  0, 0,  0,  0, 'h00, 4});

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].sa, vt[i].sb, vt[i].d, vt[i].we, vt[i].ordy, vt[i].wv, vt[i].wd, vt[i].wdat);
      #1;
      check($sformatf("vec%0d iss_ready", i), bus.iss_ready, vt[i].exp_rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d opd_valid", i), bus.opd_valid, vt[i].exp_ov);
      if (vt[i].exp_ov != 0) begin
        check($sformatf("vec%0d opd_a", i), bus.opd_a, vt[i].exp_a);
        check($sformatf("vec%0d opd_b", i), bus.opd_b, vt[i].exp_b);
        check($sformatf("vec%0d opd_dst", i), bus.opd_dst, vt[i].exp_dst);
      end
      check($sformatf("vec%0d busy", i), dut.u_sb.busy, vt[i].exp_busy);
      check($sformatf("vec%0d stall_cnt", i), stall_cnt, vt[i].exp_stall);
    end
    check("table wb_err", wb_err, 0);

    // Writeback to an idle register: written through, error flag sticks.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 1, 5, 77);
    #1;
    check("err rf_we", bus.rf_we, 1);
    check("err rf_a3", bus.rf_a3, 5);
    check("err rf_wd", bus.rf_wd, 77);
    @(posedge clk);
    #1;
    check("err wb_err set", wb_err, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("err wb_err sticky", wb_err, 1);
    check("err rf_mem[5]", rf_mem[5], 77);

    // Randomized traffic against the reference model.
    do_reset();
    check("rnd post-reset wb_err", wb_err, 0);
    m_busy = '0; m_ov = 1'b0; m_err = 1'b0; m_stall = 0;
    m_a = '0; m_b = '0; m_dst = '0; m_we = 1'b0;
    last_acc = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (last_acc || !bus.iss_valid) begin
        bus.iss_valid = ($urandom_range(0, 3) != 0);
        bus.iss_src_a = 3'($urandom_range(0, 7));
        bus.iss_src_b = 3'($urandom_range(0, 7));
        bus.iss_dst   = 3'($urandom_range(0, 7));
        bus.iss_wr_en = 1'($urandom_range(0, 1));
      end
      bus.wb_valid = 1'b0;
      bus.wb_dst   = '0;
      bus.wb_data  = 16'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 7);
        for (int j = 0; j < NREGS; j++)
          if (!bus.wb_valid && m_busy[(k + j) % NREGS]) begin
            bus.wb_valid = 1'b1;
            bus.wb_dst   = 3'((k + j) % NREGS);
          end
      end
      bus.opd_ready = ($urandom_range(0, 3) != 0);
      #1;
      ha  = bus.wb_valid && (bus.wb_dst == bus.iss_src_a);
      hb  = bus.wb_valid && (bus.wb_dst == bus.iss_src_b);
      hd  = bus.wb_valid && (bus.wb_dst == bus.iss_dst);
      haz = (m_busy[bus.iss_src_a] && !ha) || (m_busy[bus.iss_src_b] && !hb) ||
            (bus.iss_wr_en && m_busy[bus.iss_dst] && !hd);
      rdy = !haz && (!m_ov || bus.opd_ready);
      check("rnd iss_ready", bus.iss_ready, rdy);
      check("rnd rf_we", bus.rf_we, bus.wb_valid);
      acc = bus.iss_valid && rdy;
      na  = ha ? bus.wb_data : rf_mem[bus.iss_src_a];
      nb  = hb ? bus.wb_data : rf_mem[bus.iss_src_b];
      s_iv = bus.iss_valid; s_we = bus.iss_wr_en; s_d = bus.iss_dst;
      s_ordy = bus.opd_ready; s_wv = bus.wb_valid; s_wd = bus.wb_dst;
      @(posedge clk);
      if (s_iv && haz && m_stall < 65535) m_stall++;
      if (s_wv && !m_busy[s_wd]) m_err = 1'b1;
      if (s_wv) m_busy[s_wd] = 1'b0;
      if (acc && s_we) m_busy[s_d] = 1'b1;
      if (acc) begin
        m_ov = 1'b1; m_a = na; m_b = nb; m_dst = s_d; m_we = s_we;
      end else if (s_ordy) begin
        m_ov = 1'b0;
      end
      last_acc = acc;
      #1;
      check("rnd opd_valid", bus.opd_valid, m_ov);
      if (m_ov) begin
        check("rnd opd_a", bus.opd_a, m_a);
        check("rnd opd_b", bus.opd_b, m_b);
        check("rnd opd_dst", bus.opd_dst, m_dst);
        check("rnd opd_wr_en", bus.opd_wr_en, m_we);
      end
      check("rnd busy", dut.u_sb.busy, m_busy);
      check("rnd stall_cnt", stall_cnt, m_stall);
      check("rnd wb_err", wb_err, m_err);
    end

    // Stall counter saturation over 65540 hazard cycles, then release.
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 3, 1, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 3, 0, 1, 0, 1, 0, 0, 0);
    #1;
    check("sat stalled iss_ready", bus.iss_ready, 0);
    repeat (65535) @(posedge clk);
    #1;
    check("sat reach ffff", stall_cnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat hold ffff", stall_cnt, 16'hFFFF);
    check("sat still stalled", bus.iss_ready, 0);
    @(negedge clk);
    drive(1, 3, 0, 1, 0, 1, 1, 3, 40);
    #1;
    check("sat release iss_ready", bus.iss_ready, 1);
    @(posedge clk);
    #1;
    check("sat release opd_a", bus.opd_a, 40);
    check("sat release stall_cnt", stall_cnt, 16'hFFFF);

    // Asynchronous reset with a held operand and busy = 0x88.
    do_reset();
    @(negedge clk);
    drive(1, 1, 2, 3, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 7, 1, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 2, 0, 0, 0, 1, 3, 99);
    #1;
    check("arst pre opd_valid", bus.opd_valid, 1);
    check("arst pre busy", dut.u_sb.busy, 'h88);
    #1 rst = 1'b0;
    #1;
    check("arst opd_valid", bus.opd_valid, 0);
    check("arst opd_a", bus.opd_a, 0);
    check("arst busy", dut.u_sb.busy, 0);
    check("arst iss_ready", bus.iss_ready, 0);
    check("arst rf_we", bus.rf_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Operand-fetch and writeback sequencer. It is the initiator side of the 8x16 register file's two-read/one-write port. It accepts issued instructions over a valid/ready handshake, drives the register file read addresses, and captures operands into a one-entry output stage with writeback bypass. A per-register busy scoreboard stalls RAW/WAW hazards, and writeback results are forwarded onto the register file write port.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NREGS, 8, number of architectural registers (2**ADDR_W)

Reset is active-low on `rst`. It is asynchronous, and `clk` is the only clock.

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- iss_valid  in  1  issue request valid
- iss_ready  out  1  issue request accepted this cycle
- iss_src_a, iss_src_b  in  ADDR_W  source registers
- iss_dst  in  ADDR_W  destination register
- iss_wr_en  in  1  instruction writes iss_dst
- opd_valid  out  1  operand stage holds an instruction
- opd_ready  in  1  downstream consumes operand stage
- opd_a, opd_b  out  DATA_W  captured operands
- opd_dst  out  ADDR_W  captured destination
- opd_wr_en  out  1  captured write enable
- wb_valid  in  1  writeback result valid (always accepted)
- wb_dst  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback value
- rf_a1, rf_a2  out  ADDR_W  register file read addresses
- rf_a3  out  ADDR_W  register file write address
- rf_wd  out  DATA_W  register file write data
- rf_we  out  1  register file write enable
- rf_rd1, rf_rd2  in  DATA_W  register file read data (combinational read)
- wb_err  out  1  sticky: writeback to a non-busy register
- stall_cnt  out  16  saturating count of hazard-stalled cycles

## Operation
- Read addressing: rf_a1 = iss_src_a and rf_a2 = iss_src_b, combinationally, every cycle.
- Write forwarding: rf_a3 = wb_dst, rf_wd = wb_data, rf_we = wb_valid & rst.
- Scoreboard: busy[NREGS-1:0].
  - Accepted issue with iss_wr_en sets busy[iss_dst].
  - wb_valid clears busy[wb_dst].
  - If set and clear hit the same index in the same cycle, set wins.
- A writeback clears the hazard in the same cycle: wbhit(r) = wb_valid && wb_dst==r.
- hazard = (busy[src_a] && !wbhit(src_a)) || (busy[src_b] && !wbhit(src_b)) || (iss_wr_en && busy[dst] && !wbhit(dst)).
- iss_ready = rst && !hazard && (!opd_valid || opd_ready). iss_ready may depend on issue payload; the issuer must not drop iss_valid once asserted until it is accepted.
- Operand capture on accept: opd_a = wbhit(src_a) ? wb_data : rf_rd1, and likewise opd_b from rf_rd2. This bypasses the same-edge register file write.
- FSM states:
  - EMPTY: on accept, go to FULL.
  - FULL, when opd_ready and accept: reload, stay FULL.
  - FULL, when opd_ready and no accept: go to EMPTY.
  - FULL, when !opd_ready: hold all opd_* stable.
- opd_valid = (state==FULL).
- wb_err sets when wb_valid && !busy[wb_dst], and clears only on reset. The write still goes to the register file.
- stall_cnt increments when iss_valid && hazard, and saturates at 0xFFFF.
- A writeback is never blocked. A hazard never blocks the writeback that resolves it.

## Timing
- Reset values: opd_valid=0, opd_a=opd_b=0, opd_dst=0, opd_wr_en=0, busy=0, wb_err=0, stall_cnt=0, state=EMPTY.
- While rst=0: iss_ready=0 and rf_we=0.
- Reset asserted mid-operation: the held operand is dropped and the scoreboard is cleared immediately (asynchronous).
- Latency: accept at edge N gives opd_valid high after edge N.
- Throughput: one instruction per cycle while opd_ready=1 and there is no hazard.
- A writeback in cycle N releases a dependent issue in the same cycle N (zero-bubble bypass).
- A dependent issue that finds busy set, with no matching writeback, stalls until the writeback cycle.

## Structure
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, NREGS
  - state enum {EMPTY, FULL}
  - issue/operand bundle typedefs
- Sub-module rf_scoreboard holds the busy vector, set/clear priority and hazard evaluation.
- The top level holds the FSM, operand stage, bypass mux, wb_err and stall_cnt.

## Test plan
The register file is preloaded with R1=20, R2=20, R6=90, R7=1.

- **Basic issue:** issue src_a=1, src_b=6, dst=3, wr_en=1 → opd_a=20, opd_b=90, opd_dst=3, opd_valid one cycle after accept; busy[3]=1.
- **Stall, then same-cycle release:**
  - Issue src_a=3 while busy[3]=1 with no writeback → iss_ready=0; stall_cnt increments for 3 cycles.
  - Then apply wb_dst=3, wb_data=40 → accept in the same cycle, opd_a=40, busy[3]=0.
- **Backpressure:** opd_ready=0 with opd_valid=1 and a new issue pending → iss_ready=0 and opd_* stable. When opd_ready=1 → accept and reload in the same cycle.
- **WAW and set priority:**
  - Issue with dst=7 while busy[7]=1 → stalled.
  - Apply wb_dst=7 in the same cycle → accepted, and busy[7] stays 1 (set wins).
- **Error flag and saturation:**
  - wb_valid with wb_dst=5 while busy[5]=0 → rf_we=1, wb_err=1 and sticky.
  - Force 65540 stalled cycles → stall_cnt=0xFFFF.
- **Reset mid-operation:** assert rst=0 asynchronously with opd_valid=1 and busy=0x88 → opd_valid=0, busy=0, iss_ready=0, rf_we=0 immediately.
